// File: rtl/if_stage_if.sv
// IF-stage bus bundle: IF->ID instruction bus, ID->IF branch bus and the instruction-SRAM port.
interface if_stage_if;
  logic        id_allow_in;
  logic [32:0] id_to_if_branch_bus;
  logic [64:0] if_to_id_instruction_bus;
  logic        inst_sram_en;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_rdata;

  modport master (
    input  id_allow_in,
    input  id_to_if_branch_bus,
    input  inst_sram_rdata,
    output if_to_id_instruction_bus,
    output inst_sram_en,
    output inst_sram_addr
  );

  modport slave (
    output id_allow_in,
    output id_to_if_branch_bus,
    output inst_sram_rdata,
    input  if_to_id_instruction_bus,
    input  inst_sram_en,
    input  inst_sram_addr
  );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: next-PC select, IF PC/valid registers, 1-cycle SRAM fetch and a
// one-entry instruction buffer that holds returned data while ID stalls.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
  input  logic         clock,
  input  logic         reset_n,
  if_stage_if.master   bus
);

  logic        r_to_if_valid;
  logic        r_if_valid;
  logic [31:0] r_if_pc;
  logic        r_rdata_live;
  logic        r_buf_valid;
  logic [31:0] r_inst_buf;

  logic        w_br_taken;
  logic [31:0] w_br_target;
  logic        w_if_allow_in;
  logic [31:0] w_next_pc;
  logic        w_sram_en;
  logic [31:0] w_instruction;

  assign w_br_taken  = bus.id_to_if_branch_bus[32];
  assign w_br_target = bus.id_to_if_branch_bus[31:0];

  assign w_if_allow_in = !r_if_valid || bus.id_allow_in;
  // A branch only redirects when a valid delay-slot instruction is being accepted.
  assign w_next_pc     = (w_br_taken && r_if_valid) ? w_br_target : (r_if_pc + 32'd4);
  assign w_sram_en     = r_to_if_valid && w_if_allow_in;
  assign w_instruction = r_buf_valid ? r_inst_buf : bus.inst_sram_rdata;

  assign bus.inst_sram_en             = w_sram_en;
  assign bus.inst_sram_addr           = w_next_pc;
  assign bus.if_to_id_instruction_bus = {r_if_valid, r_if_pc, w_instruction};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_to_if_valid <= 1'b0;
      r_if_valid    <= 1'b0;
      r_if_pc       <= RESET_PC - 32'd4;
      r_rdata_live  <= 1'b0;
      r_buf_valid   <= 1'b0;
      r_inst_buf    <= 32'd0;
    end else begin
      r_to_if_valid <= 1'b1;
      if (w_if_allow_in) begin
        r_if_valid   <= r_to_if_valid;
        r_rdata_live <= w_sram_en;
        r_buf_valid  <= 1'b0;
        // PC advances only once a fetch is actually issued for next_pc.
        if (r_to_if_valid) begin
          r_if_pc <= w_next_pc;
        end
      end else if (r_rdata_live && r_if_valid && !bus.id_allow_in && !r_buf_valid) begin
        r_inst_buf  <= bus.inst_sram_rdata;
        r_buf_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: instruction-stream model checked every cycle plus directed literal checks.
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'hbfc0_0000;

  logic clock;
  logic reset_n;
  int   n_vec;
  int   n_err;

  if_stage_if ifc ();

  if_stage #(.RESET_PC(RESET_PC)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (ifc.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1234_5678;
  endfunction

  // Synchronous SRAM; output is garbage in any cycle that did not follow a request.
  always @(posedge clock) begin
    ifc.inst_sram_rdata <= ifc.inst_sram_en ? mem_word(ifc.inst_sram_addr) : 32'hdeadbeef;
  end

  logic        bus_valid;
  logic [31:0] bus_pc;
  logic [31:0] bus_inst;
  logic        br_taken;
  logic [31:0] br_target;
  assign bus_valid = ifc.if_to_id_instruction_bus[64];
  assign bus_pc    = ifc.if_to_id_instruction_bus[63:32];
  assign bus_inst  = ifc.if_to_id_instruction_bus[31:0];
  assign br_taken  = ifc.id_to_if_branch_bus[32];
  assign br_target = ifc.id_to_if_branch_bus[31:0];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the stream of instructions ID sees; each shown pc carries mem_word(pc).
  int          m_phase;
  logic        m_valid;
  logic [31:0] m_pc;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_phase <= 0;
      m_valid <= 1'b0;
      m_pc    <= 32'd0;
    end else if (m_phase == 0) begin
      m_phase <= 1;
    end else if (!m_valid) begin
      m_valid <= 1'b1;
      m_pc    <= RESET_PC;
    end else if (ifc.id_allow_in) begin
      m_pc <= br_taken ? br_target : m_pc + 32'd4;
    end
  end

  logic        exp_en;
  logic [31:0] exp_addr;
  always_comb begin
    exp_en   = (m_phase != 0) && (!m_valid || ifc.id_allow_in);
    exp_addr = m_valid ? (br_taken ? br_target : m_pc + 32'd4) : RESET_PC;
  end

  always @(negedge clock) begin
    if (!reset_n) begin
      chk("rst_valid", {31'd0, bus_valid}, 32'd0);
      chk("rst_en", {31'd0, ifc.inst_sram_en}, 32'd0);
    end else begin
      chk("valid", {31'd0, bus_valid}, {31'd0, m_valid});
      if (m_valid) begin
        chk("pc", bus_pc, m_pc);
        chk("instruction", bus_inst, mem_word(m_pc));
      end
      chk("en", {31'd0, ifc.inst_sram_en}, {31'd0, exp_en});
      if (exp_en) chk("addr", ifc.inst_sram_addr, exp_addr);
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic allow, input logic taken, input logic [31:0] target);
    ifc.id_allow_in         = allow;
    ifc.id_to_if_branch_bus = {taken, target};
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_vec   = 0;
    n_err   = 0;
    reset_n = 1'b0;
    drive(1'b1, 1'b0, 32'd0);
    repeat (3) cyc();
    @(negedge clock);
    chk("t1_reset_valid", {31'd0, bus_valid}, 32'd0);
    cyc();
    reset_n = 1'b1;
    // 1: first fetch after reset
    cyc();
    @(negedge clock);
    chk("t1_en", {31'd0, ifc.inst_sram_en}, 32'd1);
    chk("t1_addr", ifc.inst_sram_addr, 32'hbfc0_0000);
    cyc();
    @(negedge clock);
    chk("t1_pc", bus_pc, 32'hbfc0_0000);
    chk("t1_inst", bus_inst, 32'hadf4_5678);
    cyc();
    cyc();
    // 4: delay slot at 0xbfc00008, branch to 0xbfc00100
    drive(1'b1, 1'b1, 32'hbfc0_0100);
    @(negedge clock);
    chk("t4_pc", bus_pc, 32'hbfc0_0008);
    chk("t4_addr", ifc.inst_sram_addr, 32'hbfc0_0100);
    cyc();
    drive(1'b1, 1'b0, 32'd0);
    @(negedge clock);
    chk("t4_pc_target", bus_pc, 32'hbfc0_0100);
    // 2: straight-line run
    repeat (8) cyc();
    @(negedge clock);
    chk("t2_pc", bus_pc, 32'hbfc0_0120);
    // 3: stall across the return cycle
    cyc();
    drive(1'b0, 1'b0, 32'd0);
    repeat (2) cyc();
    @(negedge clock);
    chk("t3_en", {31'd0, ifc.inst_sram_en}, 32'd0);
    chk("t3_pc", bus_pc, 32'hbfc0_0124);
    chk("t3_inst", bus_inst, 32'hadf4_575c);
    cyc();
    drive(1'b1, 1'b0, 32'd0);
    @(negedge clock);
    chk("t3_release_addr", ifc.inst_sram_addr, 32'hbfc0_0128);
    cyc();
    // 5: branch target changes during a stall; only the accepting edge counts
    drive(1'b0, 1'b1, 32'h0000_0100);
    cyc();
    drive(1'b0, 1'b1, 32'h0000_0200);
    cyc();
    drive(1'b1, 1'b1, 32'h0000_0200);
    @(negedge clock);
    chk("t5_addr", ifc.inst_sram_addr, 32'h0000_0200);
    cyc();
    drive(1'b1, 1'b0, 32'd0);
    @(negedge clock);
    chk("t5_pc", bus_pc, 32'h0000_0200);
    chk("t5_inst", bus_inst, 32'h1234_5478);
    // wrap 0xfffffffc -> 0
    cyc();
    drive(1'b1, 1'b1, 32'hffff_fffc);
    cyc();
    drive(1'b1, 1'b0, 32'd0);
    @(negedge clock);
    chk("wrap_addr", ifc.inst_sram_addr, 32'h0000_0000);
    cyc();
    @(negedge clock);
    chk("wrap_pc", bus_pc, 32'h0000_0000);
    chk("wrap_inst", bus_inst, 32'h1234_5678);
    // 6: asynchronous reset mid-stream; taken while not valid is ignored
    cyc();
    cyc();
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_valid_drop", {31'd0, bus_valid}, 32'd0);
    chk("t6_en_drop", {31'd0, ifc.inst_sram_en}, 32'd0);
    drive(1'b1, 1'b1, 32'h0000_0300);
    repeat (2) cyc();
    reset_n = 1'b1;
    cyc();
    @(negedge clock);
    chk("t6_refetch_addr", ifc.inst_sram_addr, RESET_PC);
    cyc();
    drive(1'b1, 1'b0, 32'd0);
    @(negedge clock);
    chk("t6_refetch_pc", bus_pc, RESET_PC);
    // mixed short stalls, checked by the model
    for (int i = 0; i < 12; i++) begin
      cyc();
      drive((i % 3) != 1, 1'b0, 32'd0);
    end
    drive(1'b1, 1'b0, 32'd0);
    repeat (3) cyc();
    @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
